// File: rtl/tinker_pkg.sv
// Shared widths, reset PC and the queue entry payload for the Tinker fetch path.
package tinker_pkg;

    localparam int unsigned TINKER_ADDR_W  = 64;
    localparam int unsigned TINKER_INSTR_W = 32;
    localparam logic [TINKER_ADDR_W-1:0] TINKER_RESET_PC = 64'h2000;

    typedef struct packed {
        logic [TINKER_INSTR_W-1:0] instr;
        logic [TINKER_ADDR_W-1:0]  pc;
    } fetch_entry_t;

    localparam int unsigned FETCH_ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/tinker_sync_fifo.sv
// Small synchronous FIFO with flush and an occupancy count; head is read straight from storage.
module tinker_sync_fifo #(
    parameter int unsigned     WIDTH     = 8,
    parameter int unsigned     DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int unsigned    CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_pop;

    assign do_pop = pop && (count_q != '0);
    assign head   = mem_q[rd_ptr_q];
    assign count  = count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= RESET_VAL;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/tinker_fetch_queue.sv
// Fetch stage: owns the PC, issues credit-limited in-order reads, buffers returns for decode,
// and flushes on redirect while discarding responses still in flight for the old path.
module tinker_fetch_queue
    import tinker_pkg::*;
#(
    parameter int unsigned       ADDR_W   = TINKER_ADDR_W,
    parameter int unsigned       INSTR_W  = TINKER_INSTR_W,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(TINKER_RESET_PC)
) (
    input  logic               clk,
    input  logic               reset,
    output logic               req_valid,
    input  logic               req_ready,
    output logic [ADDR_W-1:0]  req_addr,
    input  logic               rsp_valid,
    input  logic [INSTR_W-1:0] rsp_data,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               halt
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [CNT_W-1:0]  discard_q, discard_d;
    logic [CNT_W-1:0]  occupancy;
    logic              halt_q;
    logic              req_fire;
    logic              push;
    logic              pop;
    fetch_entry_t      push_entry;
    fetch_entry_t      head_entry;

    // Credit check counts buffered plus in-flight work so every response has a slot.
    assign req_valid   = !reset && !halt_q &&
                         ((SUM_W'(occupancy) + SUM_W'(outstanding_q)) < SUM_W'(DEPTH));
    assign req_addr    = fetch_pc_q;
    assign req_fire    = req_valid && req_ready;
    assign instr_valid = (occupancy != '0);
    assign pop         = instr_valid && instr_ready;
    assign instr       = head_entry.instr;
    assign instr_pc    = head_entry.pc;

    always_comb begin
        fetch_pc_d       = fetch_pc_q;
        rsp_pc_d         = rsp_pc_q;
        discard_d        = discard_q;
        push             = 1'b0;
        push_entry.instr = rsp_data;
        push_entry.pc    = rsp_pc_q;
        outstanding_d    = outstanding_q + CNT_W'(req_fire) - CNT_W'(rsp_valid);
        if (redirect) begin
            // Everything still in flight after this cycle belongs to the old path.
            fetch_pc_d = redirect_pc & ~ADDR_W'(3);
            rsp_pc_d   = redirect_pc & ~ADDR_W'(3);
            discard_d  = outstanding_d;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + ADDR_W'(4);
            end
            if (rsp_valid) begin
                if (discard_q != '0) begin
                    discard_d = discard_q - CNT_W'(1);
                end else begin
                    push     = 1'b1;
                    rsp_pc_d = rsp_pc_q + ADDR_W'(4);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            halt_q        <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            halt_q        <= halt;
        end
    end

    tinker_sync_fifo #(
        .WIDTH     (FETCH_ENTRY_W),
        .DEPTH     (DEPTH),
        .RESET_VAL ({INSTR_W'(0), RESET_PC})
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .flush     (redirect),
        .push_data (push_entry),
        .head      (head_entry),
        .count     (occupancy)
    );

    // Memory-side protocol checks.
    a_rsp_needs_request: assert property (@(posedge clk) disable iff (reset)
        rsp_valid |-> (outstanding_q != '0));
    a_rsp_has_space: assert property (@(posedge clk) disable iff (reset)
        (rsp_valid && !redirect && (discard_q == '0)) |-> (occupancy != CNT_W'(DEPTH)));

endmodule

// File: tb/tb_tinker_fetch_queue.sv
// Bench for tinker_fetch_queue: in-order memory model, PC scoreboard, cycle table and corner sequences.
module tb_tinker_fetch_queue;
    import tinker_pkg::*;

    localparam int unsigned AW = 64;
    localparam int unsigned IW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          rsp_valid;
    logic [IW-1:0] rsp_data;
    logic          instr_valid;
    logic          instr_ready;
    logic [IW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          halt;

    always #5 clk = ~clk;

    tinker_fetch_queue #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(4), .RESET_PC(64'h2000)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
        .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt)
    );

    typedef struct {
        logic [AW-1:0] addr;
        int            due;
    } mem_req_t;

    typedef struct {
        logic          ir;
        logic          rv;
        logic [AW-1:0] ra;
        logic          iv;
        logic [AW-1:0] ipc;
    } vec_t;

    mem_req_t      pending[$];
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] pop_log[$];
    logic [AW-1:0] req_log[$];
    logic [AW-1:0] model_pc;
    vec_t          vecs[12];
    int            cyc;
    int            lat;
    int            nreq = 0;
    int            errors = 0;
    int            checks = 0;

    function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
        return 32'hA000_0001 + IW'((a - 64'h2000) >> 2);
    endfunction

    task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_rsp();
        if (pending.size() != 0 && pending[0].due <= cyc) begin
            rsp_valid = 1'b1;
            rsp_data  = mem_word(pending[0].addr);
        end else begin
            rsp_valid = 1'b0;
            rsp_data  = '0;
        end
    endtask

    // Scoreboard update for the current cycle, then advance to the next negedge.
    task automatic commit();
        mem_req_t      m;
        logic [AW-1:0] e;
        if (instr_valid && instr_ready) begin
            pop_log.push_back(instr_pc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stale_instr: got pc %h expected no instruction", instr_pc);
            end else begin
                e = exp_q.pop_front();
                check("instr_pc", instr_pc, e);
                check("instr", AW'(instr), AW'(mem_word(e)));
            end
        end
        if (rsp_valid) m = pending.pop_front();
        if (req_valid && req_ready) begin
            check("req_addr", req_addr, model_pc);
            req_log.push_back(req_addr);
            nreq++;
            pending.push_back('{addr: model_pc, due: cyc + lat});
            exp_q.push_back(model_pc);
            model_pc = model_pc + 64'd4;
        end
        if (redirect) begin
            exp_q.delete();
            model_pc = {redirect_pc[AW-1:2], 2'b00};
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic step();
        drive_rsp();
        #1;
        commit();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rsp_valid = 1'b0; rsp_data = '0; redirect = 1'b0; redirect_pc = '0;
        halt = 1'b0; instr_ready = 1'b0; req_ready = 1'b1;
        pending.delete(); exp_q.delete(); pop_log.delete(); req_log.delete();
        model_pc = 64'h2000;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cyc = 1;
    endtask

    initial begin
        int n0;
        vecs[0]  = '{1'b1, 1'b1, 64'h2000, 1'b0, 64'h0};
        vecs[1]  = '{1'b1, 1'b1, 64'h2004, 1'b0, 64'h0};
        vecs[2]  = '{1'b1, 1'b1, 64'h2008, 1'b1, 64'h2000};
        vecs[3]  = '{1'b1, 1'b1, 64'h200C, 1'b1, 64'h2004};
        vecs[4]  = '{1'b1, 1'b1, 64'h2010, 1'b1, 64'h2008};
        vecs[5]  = '{1'b0, 1'b1, 64'h2014, 1'b1, 64'h200C};
        vecs[6]  = '{1'b0, 1'b1, 64'h2018, 1'b1, 64'h200C};
        vecs[7]  = '{1'b0, 1'b0, 64'h201C, 1'b1, 64'h200C};
        vecs[8]  = '{1'b0, 1'b0, 64'h201C, 1'b1, 64'h200C};
        vecs[9]  = '{1'b1, 1'b0, 64'h201C, 1'b1, 64'h200C};
        vecs[10] = '{1'b1, 1'b1, 64'h201C, 1'b1, 64'h2010};
        vecs[11] = '{1'b1, 1'b1, 64'h2020, 1'b1, 64'h2014};

        // Reset values, then the 1-cycle memory startup table.
        reset = 1'b1;
        rsp_valid = 1'b0; rsp_data = '0; redirect = 1'b0; redirect_pc = '0;
        halt = 1'b0; instr_ready = 1'b0; req_ready = 1'b1;
        @(negedge clk); #1;
        check("rst_req_valid", AW'(req_valid), 64'd0);
        check("rst_req_addr", req_addr, 64'h2000);
        check("rst_instr_valid", AW'(instr_valid), 64'd0);
        check("rst_instr", AW'(instr), 64'd0);
        check("rst_instr_pc", instr_pc, 64'h2000);
        do_reset();
        lat = 1;
        for (int i = 0; i < 12; i++) begin
            instr_ready = vecs[i].ir;
            drive_rsp();
            #1;
            check($sformatf("vec%0d_req_valid", i), AW'(req_valid), AW'(vecs[i].rv));
            check($sformatf("vec%0d_req_addr", i), req_addr, vecs[i].ra);
            check($sformatf("vec%0d_instr_valid", i), AW'(instr_valid), AW'(vecs[i].iv));
            if (vecs[i].iv) check($sformatf("vec%0d_instr_pc", i), instr_pc, vecs[i].ipc);
            commit();
        end

        // Decode stalled: exactly DEPTH requests, head held.
        do_reset();
        lat = 1; instr_ready = 1'b0; n0 = nreq;
        repeat (12) step();
        #1;
        check("stall_req_count", AW'(nreq - n0), 64'd4);
        check("stall_req_valid", AW'(req_valid), 64'd0);
        check("stall_instr_valid", AW'(instr_valid), 64'd1);
        check("stall_instr_pc", instr_pc, 64'h2000);
        check("stall_instr", AW'(instr), 64'hA000_0001);
        instr_ready = 1'b1;
        repeat (8) step();

        // 3-cycle memory, redirect with two responses outstanding.
        do_reset();
        lat = 3; instr_ready = 1'b1;
        repeat (2) step();
        req_ready = 1'b0; redirect = 1'b1; redirect_pc = 64'h3002;
        step();
        redirect = 1'b0; req_ready = 1'b1; pop_log.delete();
        repeat (12) step();
        check("redir_pop_count", AW'(pop_log.size() >= 2), 64'd1);
        if (pop_log.size() >= 2) begin
            check("redir_first_pc", pop_log[0], 64'h3000);
            check("redir_second_pc", pop_log[1], 64'h3004);
        end

        // Redirect coinciding with a request accept and a response.
        do_reset();
        lat = 2; instr_ready = 1'b1;
        repeat (2) step();
        redirect = 1'b1; redirect_pc = 64'h5000;
        step();
        redirect = 1'b0; pop_log.delete();
        repeat (10) step();
        check("redir_same_cycle_pop", AW'(pop_log.size() >= 1), 64'd1);
        if (pop_log.size() >= 1) check("redir_same_cycle_first", pop_log[0], 64'h5000);

        // Halt with two outstanding, then redirect while halted.
        do_reset();
        lat = 3; instr_ready = 1'b1;
        step();
        halt = 1'b1;
        step();
        n0 = nreq; pop_log.delete();
        repeat (8) step();
        check("halt_no_req", AW'(nreq - n0), 64'd0);
        check("halt_delivered", AW'(pop_log.size()), 64'd2);
        if (pop_log.size() == 2) begin
            check("halt_first_pc", pop_log[0], 64'h2000);
            check("halt_second_pc", pop_log[1], 64'h2004);
        end
        redirect = 1'b1; redirect_pc = 64'h4000;
        step();
        redirect = 1'b0;
        repeat (3) step();
        #1;
        check("halt_redir_req_valid", AW'(req_valid), 64'd0);
        check("halt_redir_req_addr", req_addr, 64'h4000);
        check("halt_redir_instr_valid", AW'(instr_valid), 64'd0);
        check("halt_redir_no_req", AW'(nreq - n0), 64'd0);
        halt = 1'b0; pop_log.delete();
        repeat (8) step();
        check("unhalt_pop", AW'(pop_log.size() >= 1), 64'd1);
        if (pop_log.size() >= 1) check("unhalt_first_pc", pop_log[0], 64'h4000);

        // PC wrap at the top of the address space.
        do_reset();
        lat = 1; instr_ready = 1'b1; req_ready = 1'b0;
        redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFF9;
        step();
        redirect = 1'b0; req_ready = 1'b1; req_log.delete(); pop_log.delete();
        repeat (6) step();
        check("wrap_req_count", AW'(req_log.size() >= 4 && pop_log.size() >= 4), 64'd1);
        if (req_log.size() >= 4 && pop_log.size() >= 4) begin
            check("wrap_req0", req_log[0], 64'hFFFF_FFFF_FFFF_FFF8);
            check("wrap_req1", req_log[1], 64'hFFFF_FFFF_FFFF_FFFC);
            check("wrap_req2", req_log[2], 64'h0);
            check("wrap_req3", req_log[3], 64'h4);
            check("wrap_pop2", pop_log[2], 64'h0);
            check("wrap_pop3", pop_log[3], 64'h4);
        end

        // Sustained throughput with 2-cycle memory.
        do_reset();
        lat = 2; instr_ready = 1'b1;
        repeat (6) step();
        pop_log.delete();
        repeat (20) step();
        check("throughput", AW'(pop_log.size()), 64'd20);

        // Random traffic with redirects, halts and a mid-run reset.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            if (i == 150) do_reset();
            req_ready   = ($urandom_range(0, 3) != 0);
            instr_ready = ($urandom_range(0, 2) != 0);
            lat         = int'($urandom_range(1, 3));
            halt        = ($urandom_range(0, 9) == 0);
            redirect    = ($urandom_range(0, 15) == 0);
            redirect_pc = {$urandom, $urandom};
            step();
        end
        redirect = 1'b0; halt = 1'b0; req_ready = 1'b0; instr_ready = 1'b1;
        repeat (20) step();
        #1;
        check("drain_scoreboard_empty", AW'(exp_q.size()), 64'd0);
        check("drain_instr_valid", AW'(instr_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/tinker_fetch_queue.md
# tinker_fetch_queue

Parametrised successor to the Tinker single-cycle fetch stage: owns the program counter, issues in-order instruction read requests to a variable-latency memory port, buffers returned instructions with their PCs in a DEPTH-entry queue, and presents them to decode over a valid/ready handshake. A branch redirect flushes the queue, restarts fetch at the new target, and silently discards responses still in flight for the old path. A halt input stops new requests without losing buffered work.

## Interface
- ADDR_W, 64, PC and request address width
- INSTR_W, 32, instruction width
- DEPTH, 4, queue entries; also the cap on entries plus outstanding requests (power of two, ≥2)
- RESET_PC, 64'h2000, PC loaded on reset
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- req_valid  out  1  instruction read request valid
- req_ready  in  1  memory accepts request
- req_addr  out  ADDR_W  request address (word aligned)
- rsp_valid  in  1  one in-order response this cycle
- rsp_data  in  INSTR_W  returned instruction
- instr_valid  out  1  queue head valid
- instr_ready  in  1  decode consumes head
- instr  out  INSTR_W  head instruction
- instr_pc  out  ADDR_W  PC of head instruction
- redirect  in  1  flush and restart fetch
- redirect_pc  in  ADDR_W  restart target; bits [1:0] forced to 0
- halt  in  1  level; while high no new requests issue

## Operation
- State: fetch_pc (next request address), rsp_pc (PC of next accepted response), occupancy, outstanding, discard counter (width $clog2(DEPTH+1)).
- req_valid = !halt && (occupancy + outstanding < DEPTH); req_addr = fetch_pc. Driven from registered state only, never from redirect.
- Request handshake (req_valid && req_ready): fetch_pc += 4 modulo 2^ADDR_W; outstanding += 1.
- Response: outstanding -= 1. If discard > 0: decrement discard, drop data. Else enqueue {rsp_data, rsp_pc}; rsp_pc += 4 (wrap).
- Pop on instr_valid && instr_ready; instr_valid = occupancy != 0.
- Redirect (priority over all else): queue emptied; fetch_pc and rsp_pc ← {redirect_pc[ADDR_W-1:2], 2'b00}; discard ← outstanding_next, i.e. current outstanding plus any request accepted this cycle minus any response this cycle (that response is dropped). A pop in the redirect cycle is considered taken by decode.
- Credit rule guarantees a response always finds space; response while full is a protocol error (assertion).
- rsp_valid with outstanding == 0 is a protocol error (assertion).
- halt: requests stop next cycle; outstanding responses still enqueue; queue drains normally; redirect still honoured while halted.

## Timing
- Reset values: req_valid 0 during reset, 1 in first cycle after (halt low); req_addr RESET_PC; instr_valid 0; instr 0; instr_pc RESET_PC; all counters 0.
- Response at cycle N visible as instr_valid at N+1; no bypass. Request-to-decode minimum 2 cycles with 1-cycle memory.
- Throughput one instruction per cycle sustained when memory latency L satisfies L+1 ≤ DEPTH.
- Simultaneous push and pop: occupancy unchanged, order preserved.
- Back-to-back redirects: second overrides first; discard recomputed from live outstanding.
- Reset mid-operation: all state cleared asynchronously; memory side must also drop in-flight responses.

## Structure
- tinker_pkg: RESET_PC, INSTR_W, ADDR_W defaults, fetch_entry_t struct {instr, pc}.
- One sub-module: tinker_sync_fifo (parametrised width/depth, push/pop/flush, count output) holding fetch_entry_t; counters and PC logic in top.

## Test plan
- Reset, 1-cycle memory returning words 0xA0000001.., instr_ready high -> instr_pc 0x2000, 0x2004, 0x2008 on consecutive cycles from cycle 3.
- instr_ready low, 1-cycle memory -> exactly DEPTH=4 requests issued, req_valid drops, instr_valid held with instr_pc 0x2000.
- 3-cycle memory, redirect to 0x3002 with 2 responses outstanding -> both dropped, next instr_pc 0x3000, then 0x3004.
- Redirect same cycle as request accept and response arrival -> discard count 2 (1 old + 1 new), no stale entry reaches decode.
- halt raised with 2 outstanding -> no new req_valid; both responses delivered; redirect to 0x4000 while halted flushes, no request until halt low, then req_addr 0x4000.
- fetch_pc near 2^64-4, 1-cycle memory -> next req_addr wraps to 0x0, instr_pc sequence wraps identically.
